stream_mux: RTL and testbench
=============================

Name: stream_mux

Overview:
- Registered N-to-1 selector for the datapath, generalising the combinational bus mux to NUM_IN channels.
- Each input channel has a valid/ready handshake; the output is a one-entry register stage.
- Two channel-selection modes: a fixed mode where an explicit select picks the channel, and a round-robin arbitration mode.
- Used where several producers (writeback sources, stall-able pipeline feeds) share one consumer.

Parameters:
- NUM_IN, 4, number of input channels; must be >= 2.
- BUS_WIDTH, 32, data width per channel.
- SEL_W, derived localparam = clog2(NUM_IN); not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_IN*BUS_WIDTH  channel i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready (combinational).
- rr_en  input  1  0 = fixed mode (use sel), 1 = round-robin mode.
- sel  input  SEL_W  channel select in fixed mode; ignored when rr_en=1.
- out_data  output  BUS_WIDTH  registered data.
- out_chan  output  SEL_W  registered index of the source channel.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- bad_sel  output  1  registered; set while sel >= NUM_IN in fixed mode.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_chan=0, bad_sel=0, rr pointer ptr=0.
  - Reset asserted mid-transfer drops the held beat; no partial state survives.
- load = !out_valid || out_ready. The output stage accepts a new beat when empty or draining in the same cycle.
- Candidate channel selection:
  - Fixed mode: cand = sel, but only if sel < NUM_IN and in_valid[sel]=1. Otherwise there is no candidate.
  - Round-robin mode: cand = first i with in_valid[i]=1, scanning ptr, ptr+1, … with modulo-NUM_IN wrap. If no input is valid, there is no candidate.
- in_ready[i] = load && (a candidate exists) && (i == cand). At most one in_ready bit is high in any cycle.
- In_ready depends combinationally on in_valid and sel. Producers must not make in_valid depend on in_ready.
- Transfer on channel i = in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= in_data[i]
  - out_chan <= i
  - out_valid <= 1
- If load=1 and no candidate exists: out_valid <= 0 and out_data/out_chan hold their previous values.
- If load=0: the output register holds (stall). out_data must stay stable while out_valid && !out_ready.
- Latency: exactly 1 cycle from input transfer to out_valid. Throughput: 1 beat/cycle when out_ready=1 continuously.
- Round-robin pointer:
  - On a transfer from channel k in rr mode, ptr <= (k+1) mod NUM_IN, with explicit wrap (k = NUM_IN-1 gives 0). No reliance on power-of-2 overflow.
  - ptr is unchanged in fixed mode and on cycles with no transfer.
- bad_sel: registered each cycle as (!rr_en && sel >= NUM_IN). It is only reachable when NUM_IN is not a power of 2, and is otherwise constant 0. An out-of-range sel accepts nothing, equivalent to the zero-default arm of the plain mux.
- Mode switch: rr_en is sampled combinationally every cycle, so a switch takes effect immediately. A beat already in the output register is unaffected.
- Simultaneous events: when all inputs are valid in rr mode, grants rotate 0,1,2,…,NUM_IN-1,0. A channel holding valid is never starved for more than NUM_IN-1 transfers.

Decomposition:
- Shared package `mux_pkg`: mode encoding constants (MODE_FIXED=1'b0, MODE_RR=1'b1), and a function for modulo-NUM_IN increment.
- One natural sub-module, `rr_arbiter`: inputs are the request vector, ptr and an advance strobe; outputs are a one-hot grant, an encoded index and the registered ptr.
- The top level contains the fixed/rr select, the ready logic and the output register.

Test Plan:
- Reset mid-stall: hold out_valid=1, out_ready=0, assert rst_n=0 asynchronously (not on an edge) -> out_valid=0, out_data=0, ptr=0 immediately.
- Fixed mode, NUM_IN=4, sel=2, in_valid=4'b1111, data ch2=32'hDEAD_0002, out_ready=1 -> in_ready=4'b0100; next cycle out_data=32'hDEAD_0002, out_chan=2.
- Round-robin mode, all 4 valid, out_ready=1 for 6 cycles -> out_chan sequence 0,1,2,3,0,1; in_ready is one-hot each cycle.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b0010 -> in_ready=0 and out_data stable; on release, ch1 is accepted in the same cycle and appears the next cycle.
- Round-robin wrap: ptr=3, only ch3 and ch0 valid -> ch3 granted, then ch0; ptr goes 3 -> 0 -> 1.
- NUM_IN=3, fixed mode, sel=3 -> in_ready=3'b000, bad_sel=1 the next cycle; out_valid drops to 0 if previously drained.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the stream_mux slice: selection-mode encoding and
// the wrap-around increment used by the round-robin pointer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Explicit wrap so non-power-of-2 channel counts never rely on overflow.
    function automatic int unsigned mod_inc(input int unsigned value, input int unsigned modulus);
        if (value >= modulus - 1) begin
            return 0;
        end
        return value + 1;
    endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Bundle of the producer-side channels, mode/select controls and the
// consumer-side output stage of stream_mux.
interface stream_mux_if #(
    parameter int NUM_IN    = 4,
    parameter int BUS_WIDTH = 32,
    localparam int SEL_W    = $clog2(NUM_IN)
);

    logic [NUM_IN*BUS_WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]           in_valid;
    logic [NUM_IN-1:0]           in_ready;
    logic                        rr_en;
    logic [SEL_W-1:0]            sel;
    logic [BUS_WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]            out_chan;
    logic                        out_valid;
    logic                        out_ready;
    logic                        bad_sel;

    modport master (
        output in_data, in_valid, rr_en, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid, bad_sel
    );

    modport slave (
        input  in_data, in_valid, rr_en, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid, bad_sel
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer
// and moves the pointer just past the winner when told a transfer happened.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_IN-1:0] req,
    input  logic              advance,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              has_req,
    output logic [SEL_W-1:0]  ptr
);

    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        has_req   = 1'b0;
        idx       = 0;
        for (int off = 0; off < NUM_IN; off++) begin
            idx = int'(ptr_q) + off;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!has_req && req[idx]) begin
                has_req    = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = SEL_W'(mod_inc(int'(grant_idx), NUM_IN));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/stream_mux.sv
// Registered N-to-1 stream selector with fixed-select and round-robin modes
// feeding a one-entry output register.
module stream_mux
    import mux_pkg::*;
#(
    parameter int NUM_IN    = 4,
    parameter int BUS_WIDTH = 32,
    localparam int SEL_W    = $clog2(NUM_IN)
) (
    input  logic        clk,
    input  logic        rst_n,
    stream_mux_if.slave bus
);

    logic [NUM_IN-1:0]    arb_grant;
    logic [SEL_W-1:0]     arb_idx;
    logic                 arb_has_req;
    logic [SEL_W-1:0]     rr_ptr;
    logic                 rr_mode;
    logic                 load;
    logic                 transfer;
    logic [NUM_IN-1:0]    fixed_onehot;
    logic [NUM_IN-1:0]    cand_onehot;
    logic                 cand_valid;
    logic [SEL_W-1:0]     cand_chan;
    logic [BUS_WIDTH-1:0] cand_data;

    logic [BUS_WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]     out_chan_q,  out_chan_d;
    logic                 out_valid_q, out_valid_d;
    logic                 bad_sel_q,   bad_sel_d;

    assign rr_mode  = (bus.rr_en == MODE_RR);
    assign load     = !out_valid_q || bus.out_ready;
    assign transfer = load && cand_valid;

    rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus.in_valid),
        .advance   (transfer && rr_mode),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .has_req   (arb_has_req),
        .ptr       (rr_ptr)
    );

    // An out-of-range sel decodes to an all-zero one-hot, so it accepts nothing.
    always_comb begin
        fixed_onehot = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            fixed_onehot[i] = (int'(bus.sel) == i);
        end
    end

    always_comb begin
        cand_onehot = rr_mode ? arb_grant : (fixed_onehot & bus.in_valid);
        cand_valid  = rr_mode ? arb_has_req : (|(fixed_onehot & bus.in_valid));
        cand_chan   = rr_mode ? arb_idx : bus.sel;
        cand_data   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (cand_onehot[i]) begin
                cand_data = bus.in_data[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    assign bus.in_ready = load ? cand_onehot : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        bad_sel_d   = !rr_mode && (int'(bus.sel) >= NUM_IN);
        if (load) begin
            out_valid_d = cand_valid;
            if (cand_valid) begin
                out_data_d = cand_data;
                out_chan_d = cand_chan;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            bad_sel_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            bad_sel_q   <= bad_sel_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bad_sel   = bad_sel_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: a 4-channel instance for fixed, round-robin,
// backpressure and reset behaviour, plus a 3-channel instance for bad_sel.
module tb_stream_mux;

    logic clk;
    logic rst_n;

    int checkCount;
    int passCount;

    stream_mux_if #(.NUM_IN(4), .BUS_WIDTH(32)) bus4 ();
    stream_mux_if #(.NUM_IN(3), .BUS_WIDTH(32)) bus3 ();

    stream_mux #(.NUM_IN(4), .BUS_WIDTH(32)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    stream_mux #(.NUM_IN(3), .BUS_WIDTH(32)) u3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check is counted here and mismatches are reported.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the 4-channel controls and lets combinational ready settle.
    task automatic applyStimulus(input logic rr, input logic [1:0] s, input logic [3:0] valid, input logic ready);
        bus4.rr_en     = rr;
        bus4.sel       = s;
        bus4.in_valid  = valid;
        bus4.out_ready = ready;
        #1;
    endtask

    initial begin
        int expChan[6];
        checkCount = 0;
        passCount  = 0;
        expChan    = '{0, 1, 2, 3, 0, 1};

        rst_n          = 1'b0;
        bus4.in_data   = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
        bus4.in_valid  = '0;
        bus4.rr_en     = 1'b0;
        bus4.sel       = '0;
        bus4.out_ready = 1'b1;
        bus3.in_data   = {32'hBEEF_0002, 32'hBEEF_0001, 32'hBEEF_0000};
        bus3.in_valid  = '0;
        bus3.rr_en     = 1'b0;
        bus3.sel       = '0;
        bus3.out_ready = 1'b1;
        #2;
        checkOutput("reset_out_valid", 64'(bus4.out_valid), 64'd0);
        checkOutput("reset_out_data",  64'(bus4.out_data),  64'd0);
        checkOutput("reset_out_chan",  64'(bus4.out_chan),  64'd0);
        checkOutput("reset_bad_sel",   64'(bus4.bad_sel),   64'd0);
        checkOutput("reset_ptr",       64'(u4.rr_ptr),      64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] fixed mode, sel=2");
        applyStimulus(1'b0, 2'd2, 4'b1111, 1'b1);
        checkOutput("fixed_in_ready", 64'(bus4.in_ready), 64'b0100);
        tick();
        checkOutput("fixed_out_valid", 64'(bus4.out_valid), 64'd1);
        checkOutput("fixed_out_data",  64'(bus4.out_data),  64'hDEAD_0002);
        checkOutput("fixed_out_chan",  64'(bus4.out_chan),  64'd2);
        checkOutput("fixed_ptr_hold",  64'(u4.rr_ptr),      64'd0);

        $display("[TB] round-robin, all valid");
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        for (int c = 0; c < 6; c++) begin
            checkOutput($sformatf("rr_in_ready_%0d", c), 64'(bus4.in_ready), 64'(4'b0001 << expChan[c]));
            tick();
            checkOutput($sformatf("rr_out_chan_%0d", c), 64'(bus4.out_chan), 64'(expChan[c]));
            checkOutput($sformatf("rr_out_data_%0d", c), 64'(bus4.out_data), 64'hDEAD_0000 + 64'(expChan[c]));
        end
        checkOutput("rr_ptr_after", 64'(u4.rr_ptr), 64'd2);

        $display("[TB] backpressure on ch1");
        bus4.in_data[32 +: 32] = 32'hCAFE_0001;
        applyStimulus(1'b1, 2'd0, 4'b0010, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("stall_in_ready_%0d", c), 64'(bus4.in_ready), 64'd0);
            tick();
            checkOutput($sformatf("stall_out_data_%0d", c), 64'(bus4.out_data), 64'hDEAD_0001);
            checkOutput($sformatf("stall_out_valid_%0d", c), 64'(bus4.out_valid), 64'd1);
        end
        applyStimulus(1'b1, 2'd0, 4'b0010, 1'b1);
        checkOutput("release_in_ready", 64'(bus4.in_ready), 64'b0010);
        tick();
        checkOutput("release_out_data", 64'(bus4.out_data), 64'hCAFE_0001);
        checkOutput("release_out_chan", 64'(bus4.out_chan), 64'd1);
        checkOutput("release_ptr",      64'(u4.rr_ptr),     64'd2);

        $display("[TB] round-robin wrap");
        applyStimulus(1'b1, 2'd0, 4'b0100, 1'b1);
        tick();
        applyStimulus(1'b1, 2'd0, 4'b1001, 1'b1);
        checkOutput("wrap_ptr3",      64'(u4.rr_ptr),     64'd3);
        checkOutput("wrap_ready_ch3", 64'(bus4.in_ready), 64'b1000);
        tick();
        checkOutput("wrap_chan3",     64'(bus4.out_chan), 64'd3);
        checkOutput("wrap_ptr0",      64'(u4.rr_ptr),     64'd0);
        checkOutput("wrap_ready_ch0", 64'(bus4.in_ready), 64'b0001);
        tick();
        checkOutput("wrap_chan0",     64'(bus4.out_chan), 64'd0);
        checkOutput("wrap_ptr1",      64'(u4.rr_ptr),     64'd1);

        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        tick();
        checkOutput("idle_out_valid", 64'(bus4.out_valid), 64'd0);
        checkOutput("idle_data_hold", 64'(bus4.out_data),  64'hDEAD_0000);
        checkOutput("idle_chan_hold", 64'(bus4.out_chan),  64'd0);

        $display("[TB] 3-channel bad select");
        bus3.rr_en    = 1'b0;
        bus3.sel      = 2'd1;
        bus3.in_valid = 3'b111;
        #1;
        checkOutput("n3_in_ready_sel1", 64'(bus3.in_ready), 64'b010);
        tick();
        checkOutput("n3_out_data",  64'(bus3.out_data), 64'hBEEF_0001);
        checkOutput("n3_bad_sel_0", 64'(bus3.bad_sel),  64'd0);
        bus3.sel = 2'd3;
        #1;
        checkOutput("n3_in_ready_sel3", 64'(bus3.in_ready), 64'b000);
        tick();
        checkOutput("n3_bad_sel_1",   64'(bus3.bad_sel),   64'd1);
        checkOutput("n3_out_valid_0", 64'(bus3.out_valid), 64'd0);
        checkOutput("n3_data_hold",   64'(bus3.out_data),  64'hBEEF_0001);
        bus3.rr_en = 1'b1;
        #1;
        checkOutput("n3_rr_ready", 64'(bus3.in_ready), 64'b001);
        tick();
        checkOutput("n3_bad_sel_rr", 64'(bus3.bad_sel),  64'd0);
        checkOutput("n3_rr_chan",    64'(bus3.out_chan), 64'd0);

        $display("[TB] reset during stall");
        applyStimulus(1'b0, 2'd2, 4'b0100, 1'b0);
        tick();
        applyStimulus(1'b0, 2'd2, 4'b0000, 1'b0);
        tick();
        checkOutput("pre_reset_valid", 64'(bus4.out_valid), 64'd1);
        checkOutput("pre_reset_data",  64'(bus4.out_data),  64'hDEAD_0002);
        checkOutput("pre_reset_ptr",   64'(u4.rr_ptr),      64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 64'(bus4.out_valid), 64'd0);
        checkOutput("async_rst_data",  64'(bus4.out_data),  64'd0);
        checkOutput("async_rst_chan",  64'(bus4.out_chan),  64'd0);
        checkOutput("async_rst_ptr",   64'(u4.rr_ptr),      64'd0);
        #3;
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_valid", 64'(bus4.out_valid), 64'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
